// File: rtl/ex_mem_if.sv
// ex_mem_if: EX-to-MEM pipeline bus carrying stall control, EX results and the MAC loop-back
//   stall                 6   stall vector (bit 3 = EX stalled, bit 4 = MEM stalled)
//   ex_wd/ex_wreg/ex_wdata  EX destination, write enable, result
//   ex_whilo/ex_hi/ex_lo    EX HI/LO write enable and values
//   hilo_i/cnt_i            MAC partial product and cycle count from EX
//   mem_*                   registered copies toward MEM
//   hilo_o/cnt_o            MAC partial product and cycle count returned to EX
//   modports: master = EX side (drives ex_*), slave = ex_mem register
interface ex_mem_if;
   logic [5:0]  stall;
   logic [4:0]  ex_wd;
   logic        ex_wreg;
   logic [31:0] ex_wdata;
   logic        ex_whilo;
   logic [31:0] ex_hi;
   logic [31:0] ex_lo;
   logic [63:0] hilo_i;
   logic [1:0]  cnt_i;
   logic [4:0]  mem_wd;
   logic        mem_wreg;
   logic [31:0] mem_wdata;
   logic        mem_whilo;
   logic [31:0] mem_hi;
   logic [31:0] mem_lo;
   logic [63:0] hilo_o;
   logic [1:0]  cnt_o;
   modport master (
      output stall, ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo, hilo_i, cnt_i,
      input  mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo, hilo_o, cnt_o
   );
   modport slave (
      input  stall, ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo, hilo_i, cnt_i,
      output mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo, hilo_o, cnt_o
   );
endinterface

// File: rtl/ex_mem.sv
// ex_mem: EX/MEM pipeline register with pass/bubble/hold selection and MAC partial-product loop-back
//   clk  in  rising-edge clock
//   rst  in  synchronous active-low reset
//   bus  ex_mem_if.slave  stall, ex_* inputs, mem_* outputs, hilo/cnt loop-back
//   EX_MEM_MACC_EN: when defined, hilo_o/cnt_o carry hilo_i/cnt_i across EX stalls;
//   when undefined they are tied to 0 and no loop-back storage exists.
module ex_mem (
   input  logic    clk,
   input  logic    rst,
   ex_mem_if.slave bus
);
   typedef enum logic [1:0] {PASS, BUBBLE, HOLD} sel_e;
   localparam int W = 103;
   sel_e         sel;
   logic [W-1:0] mem_q, mem_d;
   // The illegal stall[3]=0/stall[4]=1 encoding falls into PASS.
   always_comb begin
      sel   = !bus.stall[3] ? PASS : (bus.stall[4] ? HOLD : BUBBLE);
      mem_d = sel == PASS ? {bus.ex_wd, bus.ex_wreg, bus.ex_wdata, bus.ex_whilo, bus.ex_hi, bus.ex_lo}
            : sel == BUBBLE ? '0 : mem_q;
   end
   always_ff @(posedge clk)
      if (!rst) mem_q <= '0;
      else      mem_q <= mem_d;
   assign {bus.mem_wd, bus.mem_wreg, bus.mem_wdata, bus.mem_whilo, bus.mem_hi, bus.mem_lo} = mem_q;
`ifdef EX_MEM_MACC_EN
   logic [65:0] acc_q, acc_d;
   // Any EX stall (bubble or hold) keeps the accumulate in flight.
   always_comb acc_d = sel == PASS ? '0 : {bus.hilo_i, bus.cnt_i};
   always_ff @(posedge clk)
      if (!rst) acc_q <= '0;
      else      acc_q <= acc_d;
   assign {bus.hilo_o, bus.cnt_o} = acc_q;
`else
   assign bus.hilo_o = '0;
   assign bus.cnt_o  = '0;
`endif
endmodule

// File: doc/ex_mem.md
EX_MEM -- requirements
Module: ex_mem

Interface
REQ-001 The block SHALL expose these ports (name  direction  width  meaning):
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge)
- stall  in  6  pipeline stall vector; bit 3 = EX stalled, bit 4 = MEM stalled; other bits ignored
- ex_wd  in  5  EX destination register address
- ex_wreg  in  1  EX register write enable
- ex_wdata  in  32  EX result data
- ex_whilo  in  1  EX HI/LO write enable
- ex_hi, ex_lo  in  32 each  EX HI/LO values
- hilo_i  in  64  multiply-accumulate partial product from EX
- cnt_i  in  2  multiply-accumulate cycle count from EX
- mem_wd  out  5  registered destination address to MEM
- mem_wreg  out  1  registered write enable to MEM
- mem_wdata  out  32  registered result to MEM
- mem_whilo  out  1  registered HI/LO write enable to MEM
- mem_hi, mem_lo  out  32 each  registered HI/LO to MEM
- hilo_o  out  64  partial product returned to EX
- cnt_o  out  2  cycle count returned to EX

REQ-002 All outputs SHALL be registers updated only on the clk rising edge; there is no combinational input-to-output path.

Function
REQ-003 Pass: when stall[3]=0, at the edge, mem_* SHALL load the corresponding ex_* inputs, and hilo_o and cnt_o SHALL load 0. Latency is one cycle.
REQ-004 Bubble: when stall[3]=1 and stall[4]=0, mem_wd SHALL load 5'b0, and mem_wreg, mem_whilo, mem_wdata, mem_hi and mem_lo SHALL load 0. hilo_o SHALL load hilo_i and cnt_o SHALL load cnt_i.
REQ-005 Hold: when stall[3]=1 and stall[4]=1, all mem_* outputs SHALL keep their values, hilo_o SHALL load hilo_i, and cnt_o SHALL load cnt_i.
REQ-006 The encoding stall[3]=0 with stall[4]=1 is illegal. If it occurs, REQ-003 SHALL apply.
REQ-007 The register forms a 3-state update selector: PASS, BUBBLE and HOLD, chosen each cycle from stall[4:3] only. There is no other internal state.
REQ-008 The partial-product path SHALL carry hilo_i and cnt_i unchanged (no arithmetic) across every stalled cycle, so that a two-cycle multiply-accumulate survives an EX stall of any length.
REQ-009 Data SHALL NOT be sign- or zero-extended; all widths match the ports exactly.

Reset
REQ-010 When rst=0 at an edge, every output SHALL become 0 (mem_wd = 5'b0), regardless of stall.
REQ-011 Reset SHALL take priority over all stall encodings. A reset asserted mid-accumulate SHALL clear cnt_o and hilo_o, aborting the operation.
REQ-012 Before the first edge with rst=0, output values are undefined. There is no asynchronous path.

Configuration
REQ-013 Macro EX_MEM_MACC_EN:
- Defined: hilo_i, cnt_i, hilo_o and cnt_o behave as in REQ-003 to REQ-005.
- Undefined: hilo_o and cnt_o SHALL be constant 0, hilo_i and cnt_i SHALL be ignored, and no 66-bit storage SHALL be synthesised. All mem_* behaviour is unchanged.

Verification
REQ-014 Reset: hold rst=0 for 2 edges with all inputs at 1 -> all outputs 0. Then set rst=1 and stall=0 -> one edge later, mem_* equal the ex_* inputs.
REQ-015 Pass: ex_wd=5'd7, ex_wreg=1, ex_wdata=32'hDEADBEEF, stall=0 -> next edge mem_wd=7, mem_wreg=1, mem_wdata=32'hDEADBEEF, hilo_o=0, cnt_o=0.
REQ-016 Bubble: stall=6'b001111 with hilo_i=64'h1234_5678_9ABC_DEF0 and cnt_i=2'b01 -> mem_wreg=0, mem_wdata=0, hilo_o=64'h1234_5678_9ABC_DEF0, cnt_o=1.
REQ-017 Hold: after a pass of ex_wdata=32'hA5A5A5A5, apply stall=6'b011111 for 3 cycles while ex_wdata changes -> mem_wdata stays 32'hA5A5A5A5 and hilo_o tracks hilo_i each cycle.
REQ-018 Mid-accumulate reset: cnt_i=1 and stall=6'b001111 for 1 cycle, then rst=0 -> cnt_o=0, hilo_o=0, mem_wreg=0 on the next edge.
REQ-019 Without EX_MEM_MACC_EN: repeat REQ-016 -> hilo_o=0 and cnt_o=0, with mem_* bubble values identical to REQ-016.
